alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised, handshaked successor to the 32-bit ALU: WIDTH-bit operands, 4-bit opcode, registered result plus Z/N/C/V flags. Single-cycle ops return one cycle after acceptance. MUL/MULHU run on an iterative shift-add multiplier. Valid/ready on input and output lets it sit between a register-file read stage and a writeback stage with backpressure.

Parameters:
WIDTH, 32, operand/result width; power of two, minimum 8.
MUL_EN, 1, 1 = MUL/MULHU implemented; 0 = those opcodes behave as reserved.
(Derived, not overridable: SHAMT_W = clog2(WIDTH); CNT_W = clog2(WIDTH)+1.)

Ports:
clk  in  1  clock, all state rising-edge.
rst  in  1  reset: one clock (clk); reset is synchronous and active-high.
in_valid  in  1  operand/opcode valid.
in_ready  out  1  block can accept this cycle.
a  in  WIDTH  operand A.
b  in  WIDTH  operand B (shift amount in low SHAMT_W bits).
sel  in  4  opcode.
out_valid  out  1  result/flags valid.
out_ready  in  1  consumer accepts result.
out  out  WIDTH  result.
flags  out  4  {V,C,N,Z}, bit3..bit0.

Behaviour:
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT (signed, result 1/0), 10 SLTU, 11 PASSB, 12 MUL (low WIDTH bits of unsigned product), 13 MULHU (high WIDTH bits), 14-15 reserved.
- Reserved op, or 12/13 with MUL_EN=0: out=0, flags=Z only (4'b0001), latency 1.
- Shifts use b[SHAMT_W-1:0] only; upper bits of b ignored.
- Flags: Z = (out==0); N = out[WIDTH-1]; C = carry-out for ADD, no-borrow (a>=b unsigned) for SUB, else 0; V = signed overflow for ADD/SUB, else 0.
- FSM states: IDLE, MUL, DONE.
- IDLE: in_ready=1. On accept (in_valid&in_ready), a/b/sel are captured.
  - Single-cycle op: out/flags registered; next state DONE.
  - MUL/MULHU: next state MUL; counter loads WIDTH.
- MUL: one shift-add step per cycle. in_ready=0. After exactly WIDTH cycles, result and flags are registered and the state goes to DONE. Accept-to-out_valid latency is WIDTH+1. Changes on a/b/sel during MUL are ignored.
- DONE: out_valid=1; out/flags held stable until out_ready.
  - out_ready=1 and in_valid=1: in_ready=1 (combinational from out_ready), a new op is accepted the same cycle, and the state follows the accept rules above. Throughput is 1 op/cycle for single-cycle ops.
  - out_ready=1 and in_valid=0: go to IDLE; out_valid drops next cycle.
  - out_ready=0: stay in DONE; in_ready=0.
- Reset values: state IDLE, out_valid 0, out 0, flags 0, counter 0, in_ready 1 from the first cycle after reset.
- rst asserted mid-MUL or in DONE: operation abandoned; no out_valid is produced for it.
- Multiplier product register is 2*WIDTH bits; no rounding or saturation.
- All arithmetic wraps modulo 2^WIDTH.

Decomposition:
- Package alu_pkg:
  - opcode localparams (OP_ADD..OP_MULHU);
  - flag bit indices (FLG_Z=0, FLG_N=1, FLG_C=2, FLG_V=3);
  - FSM state encoding (ST_IDLE, ST_MUL, ST_DONE).
- Sub-module alu_mul_iter: start/a/b in, done/product[2*WIDTH-1:0] out, WIDTH-cycle shift-add, instantiated under MUL_EN.
- Combinational op decode and flag generation stay in alu_seq.

Test Plan:
- Reset; then a=1, b=1, sel=ADD, held 1 cycle -> out_valid next cycle, out=0x00000002, flags=0000; in_ready=1 throughout.
- ADD 0x7FFFFFFF+0x00000001 -> out=0x80000000, V=1, N=1, C=0, Z=0. SUB 0x00000000-0x00000001 -> 0xFFFFFFFF, C=0, N=1. SUB 5-5 -> 0, Z=1, C=1.
- MUL a=0xFFFFFFFF, b=2 -> in_ready=0 for 32 cycles; out_valid exactly 33 cycles after accept; out=0xFFFFFFFE. Repeat with MULHU -> out=0x00000001.
- Shifts and reserved: SRA 0x80000000 by b=35 (shamt 3) -> 0xF0000000. SLT 0xFFFFFFFF vs 1 -> 1; SLTU -> 0. sel=15 -> out=0, flags=0001.
- Backpressure: out_ready=0 for 5 cycles after a result -> out/flags stable, in_ready=0. Then out_ready=1 with a new ADD valid -> accepted that cycle; next result 1 cycle later. Issue 4 back-to-back ADDs with out_ready=1 -> 4 results on 4 consecutive cycles.
- Reset mid-MUL at cycle 10 of 32 -> next cycle out_valid=0, out=0, flags=0, in_ready=1. No stale result appears; a following ADD 2+3 returns 5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the sequenced ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOR   = 4'd5;
  localparam logic [3:0] OP_SLL   = 4'd6;
  localparam logic [3:0] OP_SRL   = 4'd7;
  localparam logic [3:0] OP_SRA   = 4'd8;
  localparam logic [3:0] OP_SLT   = 4'd9;
  localparam logic [3:0] OP_SLTU  = 4'd10;
  localparam logic [3:0] OP_PASSB = 4'd11;
  localparam logic [3:0] OP_MUL   = 4'd12;
  localparam logic [3:0] OP_MULHU = 4'd13;

  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;
  localparam int FLG_V = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one partial-product step per cycle, WIDTH steps.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   mcand_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH:0]     sum;

  // Upper half accumulates the multiplicand; lower half starts as the multiplier and shifts out.
  always_comb begin
    sum      = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, mcand_reg} : '0);
    acc_next = {sum, acc_reg[WIDTH-1:1]};
  end

  // done marks the cycle of the final step; product is that step's result, ready to be registered.
  assign done    = (cnt_reg == CNT_W'(1));
  assign product = acc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      mcand_reg <= '0;
      acc_reg   <= '0;
    end else if (start) begin
      cnt_reg   <= CNT_W'(WIDTH);
      mcand_reg <= a;
      acc_reg   <= {{WIDTH{1'b0}}, b};
    end else if (cnt_reg != '0) begin
      acc_reg <= acc_next;
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith ops plus optional iterative MUL/MULHU, registered result and flags.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flags
);

  localparam int SHAMT_W = $clog2(WIDTH);

  state_t             state_reg;
  logic               out_valid_reg;
  logic [WIDTH-1:0]   out_reg;
  logic [3:0]         flags_reg;
  logic [3:0]         sel_reg;

  logic               accept;
  logic               is_mul_op;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH:0]     add_w;
  logic [WIDTH:0]     sub_w;
  logic [WIDTH-1:0]   alu_res;
  logic [3:0]         alu_flg;

  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH-1:0]   mul_res;
  logic [3:0]         mul_flg;

  // in_ready depends combinationally on out_ready so a DONE result can be drained and replaced in one cycle.
  assign in_ready  = (state_reg == ST_IDLE) || ((state_reg == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul_op = (MUL_EN != 0) && ((sel == OP_MUL) || (sel == OP_MULHU));
  assign mul_start = accept && is_mul_op;
  assign shamt     = b[SHAMT_W-1:0];

  always_comb begin
    add_w   = {1'b0, a} + {1'b0, b};
    sub_w   = {1'b0, a} - {1'b0, b};
    alu_res = '0;
    alu_flg = '0;
    case (sel)
      OP_ADD: begin
        alu_res        = add_w[WIDTH-1:0];
        alu_flg[FLG_C] = add_w[WIDTH];
        alu_flg[FLG_V] = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res        = sub_w[WIDTH-1:0];
        alu_flg[FLG_C] = ~sub_w[WIDTH];
        alu_flg[FLG_V] = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:   alu_res = a & b;
      OP_OR:    alu_res = a | b;
      OP_XOR:   alu_res = a ^ b;
      OP_NOR:   alu_res = ~(a | b);
      OP_SLL:   alu_res = a << shamt;
      OP_SRL:   alu_res = a >> shamt;
      OP_SRA:   alu_res = WIDTH'($signed(a) >>> shamt);
      OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_PASSB: alu_res = b;
      default:  alu_res = '0;
    endcase
    alu_flg[FLG_Z] = (alu_res == '0);
    alu_flg[FLG_N] = alu_res[WIDTH-1];
  end

  generate
    if (MUL_EN != 0) begin : g_mul
      alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
      );
    end else begin : g_no_mul
      assign mul_done    = 1'b0;
      assign mul_product = '0;
    end
  endgenerate

  always_comb begin
    mul_res        = (sel_reg == OP_MULHU) ? mul_product[2*WIDTH-1:WIDTH] : mul_product[WIDTH-1:0];
    mul_flg        = '0;
    mul_flg[FLG_Z] = (mul_res == '0);
    mul_flg[FLG_N] = mul_res[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      out_valid_reg <= 1'b0;
      out_reg       <= '0;
      flags_reg     <= '0;
      sel_reg       <= OP_ADD;
    end else if (accept) begin
      sel_reg <= sel;
      if (is_mul_op) begin
        state_reg     <= ST_MUL;
        out_valid_reg <= 1'b0;
      end else begin
        state_reg     <= ST_DONE;
        out_valid_reg <= 1'b1;
        out_reg       <= alu_res;
        flags_reg     <= alu_flg;
      end
    end else begin
      case (state_reg)
        ST_MUL: begin
          if (mul_done) begin
            state_reg     <= ST_DONE;
            out_valid_reg <= 1'b1;
            out_reg       <= mul_res;
            flags_reg     <= mul_flg;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_reg     <= ST_IDLE;
            out_valid_reg <= 1'b0;
          end
        end
        ST_IDLE: ;
        default: begin
          state_reg     <= ST_IDLE;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign out       = out_reg;
  assign flags     = flags_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq against a plain-arithmetic reference model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic [3:0]  flags;

  int vectors     = 0;
  int miscompares = 0;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32), .MUL_EN(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .flags     (flags)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {V,C,N,Z,result} computed with wide integer arithmetic.
  function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y, input logic [3:0] op);
    longint          sx, sy, sr;
    longint unsigned ux, uy, p;
    logic [31:0]     r;
    logic            c, v;
    int              sh;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = int'(y % 32);
    c  = 1'b0;
    v  = 1'b0;
    p  = 0;
    sr = 0;
    case (op)
      4'd0:  begin p = ux + uy; r = p[31:0]; c = (p >= 64'h1_0000_0000); sr = sx + sy; v = (sr > SMAX) || (sr < SMIN); end
      4'd1:  begin r = x - y; c = (ux >= uy); sr = sx - sy; v = (sr > SMAX) || (sr < SMIN); end
      4'd2:  r = x & y;
      4'd3:  r = x | y;
      4'd4:  r = x ^ y;
      4'd5:  r = ~(x | y);
      4'd6:  r = x << sh;
      4'd7:  r = x >> sh;
      4'd8:  begin sr = sx >>> sh; r = sr[31:0]; end
      4'd9:  r = (sx < sy) ? 32'd1 : 32'd0;
      4'd10: r = (ux < uy) ? 32'd1 : 32'd0;
      4'd11: r = y;
      4'd12: begin p = ux * uy; r = p[31:0]; end
      4'd13: begin p = ux * uy; r = p[63:32]; end
      default: r = 32'd0;
    endcase
    return {v, c, r[31], (r == 32'd0), r};
  endfunction

  // Issue one op with out_ready held high; check latency, busy cycles, result and flags.
  task automatic run_op(input logic [31:0] xa, input logic [31:0] xb, input logic [3:0] op);
    logic [35:0] e;
    int          lat;
    int          stall;
    int          exp_lat;
    e       = model(xa, xb, op);
    exp_lat = (op == 4'd12 || op == 4'd13) ? 33 : 1;
    @(negedge clk);
    a = xa; b = xb; sel = op; in_valid = 1'b1; out_ready = 1'b1;
    check("in_ready_at_issue", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; sel = 4'($urandom);
    lat   = 1;
    stall = 0;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      if (!in_ready) stall++;
      @(negedge clk);
      lat++;
    end
    check("latency", lat, exp_lat);
    check("busy_cycles", stall, exp_lat - 1);
    check("out", out, e[31:0]);
    check("flags", flags, e[35:32]);
    $display("op=%0d a=%h b=%h -> out=%h flags=%b lat=%0d", op, xa, xb, out, flags, lat);
  endtask

  initial begin
    logic [35:0] e;
    logic [31:0] held_out;
    logic [3:0]  held_flags;
    logic [31:0] ba [4];
    logic [31:0] bb [4];
    logic        seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sel = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_out", out, 0);
    check("reset_flags", flags, 0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    $display("reset done");

    // Directed cases
    run_op(32'h1, 32'h1, 4'd0);
    run_op(32'h7FFFFFFF, 32'h1, 4'd0);
    run_op(32'h0, 32'h1, 4'd1);
    run_op(32'h5, 32'h5, 4'd1);
    run_op(32'hFFFFFFFF, 32'h2, 4'd12);
    run_op(32'hFFFFFFFF, 32'h2, 4'd13);
    run_op(32'h80000000, 32'd35, 4'd8);
    run_op(32'hFFFFFFFF, 32'h1, 4'd9);
    run_op(32'hFFFFFFFF, 32'h1, 4'd10);
    run_op(32'h12345678, 32'h9, 4'd15);
    run_op(32'h12345678, 32'h9, 4'd14);

    // Backpressure: hold result for 5 cycles, then drain and accept in the same cycle
    e = model(32'd10, 32'd20, 4'd0);
    @(negedge clk);
    a = 32'd10; b = 32'd20; sel = 4'd0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    held_out   = out;
    held_flags = flags;
    check("bp_first_out", held_out, e[31:0]);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_held", out_valid, 1);
      check("bp_out_stable", out, e[31:0]);
      check("bp_flags_stable", flags, e[35:32]);
      check("bp_in_ready_low", in_ready, 0);
      @(negedge clk);
    end
    $display("backpressure hold out=%h flags=%b", held_out, held_flags);
    e = model(32'd100, 32'd23, 4'd0);
    out_ready = 1'b1; in_valid = 1'b1; a = 32'd100; b = 32'd23; sel = 4'd0;
    #1 check("bp_in_ready_comb", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_valid", out_valid, 1);
    check("bp_next_out", out, e[31:0]);
    $display("backpressure release out=%h", out);

    // Four back-to-back ADDs
    for (int i = 0; i < 4; i++) begin
      ba[i] = $urandom;
      bb[i] = $urandom;
    end
    @(negedge clk);
    a = ba[0]; b = bb[0]; sel = 4'd0; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      e = model(ba[i], bb[i], 4'd0);
      check("b2b_valid", out_valid, 1);
      check("b2b_out", out, e[31:0]);
      check("b2b_flags", flags, e[35:32]);
      $display("b2b[%0d] a=%h b=%h -> out=%h", i, ba[i], bb[i], out);
      if (i < 3) begin
        a = ba[i+1]; b = bb[i+1];
      end else begin
        in_valid = 1'b0;
      end
    end

    // Randomised ops, biased towards interesting operands now and then
    for (int n = 0; n < 60; n++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
      if ($urandom_range(0, 5) == 0) rb = ra;
      if ($urandom_range(0, 7) == 0) rb = 32'hFFFFFFFF;
      run_op(ra, rb, 4'($urandom_range(0, 15)));
    end

    // Reset during a multiply: nothing from it may surface
    @(negedge clk);
    a = 32'h1234; b = 32'h5678; sel = 4'd12; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midmul_out_valid", out_valid, 0);
    check("midmul_out", out, 0);
    check("midmul_flags", flags, 0);
    check("midmul_in_ready", in_ready, 1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midmul_no_stale", seen, 0);
    $display("reset mid-multiply, stale result seen=%0d", seen);
    run_op(32'd2, 32'd3, 4'd0);
    check("after_reset_add", out, 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
